// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM status, machine word and arbiter request kinds.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic [1:0] {
      REQ_IREAD  = 2'b00,
      REQ_DREAD  = 2'b01,
      REQ_DWRITE = 2'b10
   } req_kind_t;

   // Two-way round-robin: a lone requester wins, a tie goes to the favoured core.
   function automatic logic rr_pick(input logic [1:0] req, input logic favour);
      return (req == 2'b11) ? favour : req[1];
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational requester selection: data write > data read > instruction read,
// round-robin between cores within a class; data reads are masked while c2c is active.
module arb_pick
   import cpu_types_pkg::*;
(
   input  logic      [1:0] iren_i,
   input  logic      [1:0] dren_i,
   input  logic      [1:0] dwen_i,
   input  logic            c2c_i,
   input  logic            rr_i,
   output logic            vld_o,
   output logic            core_o,
   output req_kind_t       kind_o
);

   logic [1:0] dren_elig;

   assign dren_elig = dren_i & ~{2{c2c_i}};

   always_comb begin
      vld_o  = 1'b1;
      core_o = 1'b0;
      kind_o = REQ_IREAD;
      if (|dwen_i) begin
         kind_o = REQ_DWRITE;
         core_o = rr_pick(dwen_i, rr_i);
      end else if (|dren_elig) begin
         kind_o = REQ_DREAD;
         core_o = rr_pick(dren_elig, rr_i);
      end else if (|iren_i) begin
         kind_o = REQ_IREAD;
         core_o = rr_pick(iren_i, rr_i);
      end else begin
         vld_o = 1'b0;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Two-core arbiter onto a single RAM port: IDLE picks and latches a request, GRANT
// holds the strobe until ACCESS (retrying on ERROR), DONE idles one cycle for the requester.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int   CPUS    = 2,
   parameter logic RR_INIT = 1'b0
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic      [1:0] iREN,
   input  word_t           iaddr0,
   input  word_t           iaddr1,
   input  logic      [1:0] dREN,
   input  logic      [1:0] dWEN,
   input  word_t           daddr0,
   input  word_t           daddr1,
   input  word_t           dstore0,
   input  word_t           dstore1,
   input  logic            c2c,
   input  ramstate_t       ramstate,
   input  word_t           ramload,
   output logic      [1:0] iwait,
   output logic      [1:0] dwait,
   output word_t           iload,
   output word_t           dload,
   output word_t           ramaddr,
   output word_t           ramstore,
   output logic            ramREN,
   output logic            ramWEN
);

   localparam int CW = $clog2(CPUS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          rr_q, rr_d;
   logic [CW-1:0] core_q, core_d;
   req_kind_t     kind_q, kind_d;
   word_t         addr_q, addr_d;
   word_t         data_q, data_d;

   logic          pick_vld;
   logic          pick_core;
   req_kind_t     pick_kind;
   logic          granted_act;
   logic          done_now;
   logic [1:0]    core_oh;
   logic [1:0]    i_cpl;
   logic [1:0]    d_cpl;

   arb_pick u_pick (
      .iren_i (iREN),
      .dren_i (dREN),
      .dwen_i (dWEN),
      .c2c_i  (c2c),
      .rr_i   (rr_q),
      .vld_o  (pick_vld),
      .core_o (pick_core),
      .kind_o (pick_kind)
   );

   // The granted request must still be held; a dropped request kills the strobe at once.
   always_comb begin
      granted_act = 1'b0;
      case (kind_q)
         REQ_DWRITE: granted_act = dWEN[core_q];
         REQ_DREAD:  granted_act = dREN[core_q];
         default:    granted_act = iREN[core_q];
      endcase
   end

   assign done_now = (state_q == GRANT) && granted_act && (ramstate == ACCESS);
   assign core_oh  = core_q ? 2'b10 : 2'b01;
   assign i_cpl    = (done_now && kind_q == REQ_IREAD) ? core_oh : 2'b00;
   assign d_cpl    = (done_now && kind_q != REQ_IREAD) ? core_oh : 2'b00;

   assign iwait    = iREN & ~i_cpl;
   assign dwait    = (dREN | dWEN) & ~d_cpl;
   assign iload    = ramload;
   assign dload    = ramload;
   assign ramaddr  = addr_q;
   assign ramstore = data_q;
   assign ramREN   = (state_q == GRANT) && granted_act && (kind_q != REQ_DWRITE);
   assign ramWEN   = (state_q == GRANT) && granted_act && (kind_q == REQ_DWRITE);

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      core_d  = core_q;
      kind_d  = kind_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d = GRANT;
               core_d  = pick_core;
               kind_d  = pick_kind;
               data_d  = pick_core ? dstore1 : dstore0;
               if (pick_kind == REQ_IREAD) begin
                  addr_d = pick_core ? iaddr1 : iaddr0;
               end else begin
                  addr_d = pick_core ? daddr1 : daddr0;
               end
            end
         end
         GRANT: begin
            if (!granted_act) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               state_d = DONE;
               rr_d    = ~core_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         rr_q    <= RR_INIT;
         core_q  <= '0;
         kind_q  <= REQ_IREAD;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         core_q  <= core_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: inputs driven on the falling edge, outputs checked 1ns later.
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic      CLK = 1'b0;
   logic      nRST;
   logic [1:0] iREN, dREN, dWEN;
   word_t     iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1;
   logic      c2c;
   ramstate_t ramstate;
   word_t     ramload;
   logic [1:0] iwait, dwait;
   word_t     iload, dload, ramaddr, ramstore;
   logic      ramREN, ramWEN;

   int        n_cmp = 0;
   int        n_err = 0;
   word_t     got [0:7];
   int        ng;
   int        hi, lo;

   memory_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
      .dREN(dREN), .dWEN(dWEN),
      .daddr0(daddr0), .daddr1(daddr1), .dstore0(dstore0), .dstore1(dstore1),
      .c2c(c2c), .ramstate(ramstate), .ramload(ramload),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Both cores hold data reads against an always-ready RAM; grant addresses are logged in order.
   task automatic run_both(input int ntx);
      dREN = 2'b11; daddr0 = 32'h200; daddr1 = 32'h300; ramstate = ACCESS;
      ng = 0;
      repeat (3 * ntx) begin
         #1;
         if (ramREN === 1'b1) begin
            if (ng < 8) got[ng] = ramaddr;
            ng++;
         end
         chk("strobe_excl", {31'd0, ramREN & ramWEN}, 32'd0);
         @(negedge CLK);
      end
      dREN = 2'b00;
   endtask

   initial begin
      nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; c2c = 1'b0;
      iaddr0 = '0; iaddr1 = '0; daddr0 = '0; daddr1 = '0; dstore0 = '0; dstore1 = '0;
      ramstate = FREE; ramload = 32'h1234_5678;

      // Reset state
      @(negedge CLK); #1;
      chk("rst_ren", {31'd0, ramREN}, 32'd0);
      chk("rst_wen", {31'd0, ramWEN}, 32'd0);
      chk("rst_addr", ramaddr, 32'd0);
      chk("rst_store", ramstore, 32'd0);
      chk("iload", iload, 32'h1234_5678);
      chk("dload", dload, 32'h1234_5678);
      @(negedge CLK); nRST = 1'b1;

      // Instruction fetch, two BUSY then ACCESS
      @(negedge CLK); iREN = 2'b01; iaddr0 = 32'h40; ramstate = BUSY; #1;
      chk("t1_idle_ren", {31'd0, ramREN}, 32'd0);
      chk("t1_idle_iwait", {30'd0, iwait}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (c == 2) ramstate = ACCESS;
         #1;
         chk("t1_ren", {31'd0, ramREN}, 32'd1);
         chk("t1_addr", ramaddr, 32'h40);
         chk("t1_iwait", {30'd0, iwait}, (c == 2) ? 32'd0 : 32'd1);
      end
      @(negedge CLK); iREN = 2'b00; ramstate = FREE; #1;
      chk("t1_done_ren", {31'd0, ramREN}, 32'd0);

      // Data write beats a simultaneous fetch; fetch follows after DONE
      @(negedge CLK);
      dWEN = 2'b01; daddr0 = 32'h100; dstore0 = 32'hDEAD; iREN = 2'b10; iaddr1 = 32'h80;
      ramstate = ACCESS; #1;
      chk("t2_idle_wen", {31'd0, ramWEN}, 32'd0);
      chk("t2_idle_dwait", {30'd0, dwait}, 32'd1);
      @(negedge CLK); #1;
      chk("t2_wen", {31'd0, ramWEN}, 32'd1);
      chk("t2_ren", {31'd0, ramREN}, 32'd0);
      chk("t2_waddr", ramaddr, 32'h100);
      chk("t2_wdata", ramstore, 32'hDEAD);
      chk("t2_dwait", {30'd0, dwait}, 32'd0);
      chk("t2_iwait_hold", {30'd0, iwait}, 32'd2);
      @(negedge CLK); dWEN = 2'b00; #1;
      chk("t2_done_wen", {31'd0, ramWEN}, 32'd0);
      chk("t2_done_ren", {31'd0, ramREN}, 32'd0);
      @(negedge CLK); #1;
      chk("t2_idle2_ren", {31'd0, ramREN}, 32'd0);
      @(negedge CLK); #1;
      chk("t2_fetch_ren", {31'd0, ramREN}, 32'd1);
      chk("t2_fetch_addr", ramaddr, 32'h80);
      chk("t2_fetch_iwait", {30'd0, iwait}, 32'd0);
      @(negedge CLK); iREN = 2'b00; #1;
      @(negedge CLK);

      // Round robin between two continuous data readers
      run_both(4);
      chk("t3_count", ng, 32'd4);
      chk("t3_g0", got[0], 32'h200);
      chk("t3_g1", got[1], 32'h300);
      chk("t3_g2", got[2], 32'h200);
      chk("t3_g3", got[3], 32'h300);

      // c2c masks data reads but lets the write through
      c2c = 1'b1; dREN = 2'b10; dWEN = 2'b01; daddr0 = 32'h400; dstore0 = 32'hBEEF;
      daddr1 = 32'h500; #1;
      chk("t4_idle_dwait", {30'd0, dwait}, 32'd3);
      @(negedge CLK); #1;
      chk("t4_wen", {31'd0, ramWEN}, 32'd1);
      chk("t4_ren", {31'd0, ramREN}, 32'd0);
      chk("t4_addr", ramaddr, 32'h400);
      chk("t4_data", ramstore, 32'hBEEF);
      chk("t4_dwait", {30'd0, dwait}, 32'd2);
      @(negedge CLK); dWEN = 2'b00; #1;
      chk("t4_done_wen", {31'd0, ramWEN}, 32'd0);
      repeat (4) begin
         @(negedge CLK); #1;
         chk("t4_no_ren", {31'd0, ramREN}, 32'd0);
         chk("t4_stall", {30'd0, dwait}, 32'd2);
      end
      dREN = 2'b00; c2c = 1'b0;

      // ERROR twice, then ACCESS
      @(negedge CLK); iREN = 2'b01; iaddr0 = 32'h60; ramstate = ERROR; #1;
      hi = 0; lo = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (c == 2) ramstate = ACCESS;
         #1;
         if (ramREN === 1'b1) hi++;
         if (iwait[0] === 1'b0) lo++;
         chk("t5_ren", {31'd0, ramREN}, 32'd1);
      end
      @(negedge CLK); iREN = 2'b00; #1;
      chk("t5_done_ren", {31'd0, ramREN}, 32'd0);
      chk("t5_strobe_cycles", hi, 32'd3);
      chk("t5_wait_pulses", lo, 32'd1);

      // Request dropped mid-grant: strobe falls, pointer unchanged
      @(negedge CLK); iREN = 2'b10; iaddr1 = 32'h70; ramstate = BUSY;
      @(negedge CLK); #1;
      chk("t6_ren", {31'd0, ramREN}, 32'd1);
      chk("t6_addr", ramaddr, 32'h70);
      @(negedge CLK); iREN = 2'b00; #1;
      chk("t6_drop_ren", {31'd0, ramREN}, 32'd0);
      @(negedge CLK);
      run_both(2);
      chk("t6_count", ng, 32'd2);
      chk("t6_g0", got[0], 32'h300);
      chk("t6_g1", got[1], 32'h200);

      // Reset mid-grant: strobes drop at once, no completion, pointer back to RR_INIT
      iREN = 2'b10; iaddr1 = 32'h90; ramstate = BUSY;
      @(negedge CLK); #1;
      chk("t7_ren", {31'd0, ramREN}, 32'd1);
      #2 nRST = 1'b0; #1;
      chk("t7_rst_ren", {31'd0, ramREN}, 32'd0);
      chk("t7_rst_addr", ramaddr, 32'd0);
      chk("t7_rst_iwait", {30'd0, iwait}, 32'd2);
      @(negedge CLK); nRST = 1'b1; iREN = 2'b00; #1;
      chk("t7_idle_ren", {31'd0, ramREN}, 32'd0);
      @(negedge CLK);
      run_both(1);
      chk("t7_count", ng, 32'd1);
      chk("t7_g0", got[0], 32'h200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not complete");
   end

endmodule
